// File: rtl/block_sched_if.sv
// Control/status bundle between the game controller and the falling-block scheduler.
interface block_sched_if #(
  parameter int NSLOT = 4
);
  logic                 restart;
  logic                 start;
  logic                 pause;
  logic                 fall_tick;
  logic [6:0]           beat_cnt;
  logic [10*NSLOT-1:0]  slot_h;
  logic [3*NSLOT-1:0]   slot_lane;
  logic [NSLOT-1:0]     slot_valid;
  logic [1:0]           state;
  logic [7:0]           drop_cnt;

  modport master (
    output restart, start, pause, fall_tick, beat_cnt,
    input  slot_h, slot_lane, slot_valid, state, drop_cnt
  );

  modport slave (
    input  restart, start, pause, fall_tick, beat_cnt,
    output slot_h, slot_lane, slot_valid, state, drop_cnt
  );
endinterface

// File: rtl/block_sched.sv
// Falling-block slot scheduler: beat-driven lane requests, slot allocation and fall.
// Define BLOCK_SCHED_DROP_CNT_EN to build the refused-request counter behind drop_cnt.
module block_sched #(
  parameter int NSLOT     = 4,
  parameter int SPAWN_H   = 120,
  parameter int FLOOR_H   = 720,
  parameter int LAST_BEAT = 80
) (
  input logic          clk,
  input logic          rst,
  block_sched_if.slave bus
);
  localparam int IDX_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_PAUSE = 2'b10,
    S_END   = 2'b11
  } state_t;

  state_t           state_reg, state_next;
  logic [6:0]       pre_beat_reg;
  logic [4:0]       pending_reg, pending_next;
  logic [9:0]       h_reg     [NSLOT];
  logic [2:0]       lane_reg  [NSLOT];
  logic             valid_reg [NSLOT];

  logic                 clear;
  logic                 play;
  logic                 beat_add;
  logic [6:0]           half;
  logic [2:0]           lane_a, lane_b;
  logic [4:0]           beat_mask;
  logic                 req_found;
  logic [2:0]           req_lane;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  logic                 alloc_en;
  logic [NSLOT-1:0]     valid_vec;
  logic [10*NSLOT-1:0]  slot_h_vec;
  logic [3*NSLOT-1:0]   slot_lane_vec;

  assign clear    = rst || bus.restart;
  assign play     = (state_reg == S_PLAY);
  assign beat_add = bus.beat_cnt > pre_beat_reg;

  // Beatmap: even beats 4..76 request lane (b/2) mod 5, multiples of 16 add (b/2+2) mod 5.
  assign half   = {1'b0, bus.beat_cnt[6:1]};
  assign lane_a = 3'(half % 7'd5);
  assign lane_b = 3'((half + 7'd2) % 7'd5);

  always_comb begin
    beat_mask = '0;
    if (!bus.beat_cnt[0] && bus.beat_cnt >= 7'd4 && bus.beat_cnt <= 7'd76) begin
      beat_mask = 5'b00001 << lane_a;
      if (bus.beat_cnt[3:0] == 4'd0) begin
        beat_mask = beat_mask | (5'b00001 << lane_b);
      end
    end
  end

  always_comb begin
    req_found = 1'b0;
    req_lane  = '0;
    for (int i = 0; i < 5; i++) begin
      if (!req_found && pending_reg[i]) begin
        req_found = 1'b1;
        req_lane  = 3'(i);
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (!free_found && !valid_reg[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign alloc_en = play && req_found && free_found;

  // The serviced (or refused) bit clears first so a same-lane beat arriving now survives.
  always_comb begin
    pending_next = pending_reg;
    if (play) begin
      if (req_found) begin
        pending_next[req_lane] = 1'b0;
      end
      if (beat_add) begin
        pending_next = pending_next | beat_mask;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.start) state_next = S_PLAY;
      S_PLAY: begin
        if (bus.pause) begin
          state_next = S_PAUSE;
        end else if (bus.beat_cnt >= 7'(LAST_BEAT) && pending_reg == 5'd0 && valid_vec == '0) begin
          state_next = S_END;
        end
      end
      S_PAUSE: if (!bus.pause) state_next = S_PLAY;
      S_END:   state_next = S_END;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg    <= S_IDLE;
      pre_beat_reg <= '0;
      pending_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      pre_beat_reg <= bus.beat_cnt;
      pending_reg  <= pending_next;
    end
  end

  // Allocation only targets free slots and fall only touches valid ones, so they never collide.
  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
    logic [10:0] h_inc;
    assign h_inc = {1'b0, h_reg[gi]} + 11'd1;

    always_ff @(posedge clk) begin
      if (clear) begin
        valid_reg[gi] <= 1'b0;
        h_reg[gi]     <= 10'(FLOOR_H);
        lane_reg[gi]  <= '0;
      end else if (alloc_en && free_idx == IDX_W'(gi)) begin
        valid_reg[gi] <= 1'b1;
        h_reg[gi]     <= 10'(SPAWN_H);
        lane_reg[gi]  <= req_lane;
      end else if (play && bus.fall_tick && valid_reg[gi]) begin
        if (h_inc >= 11'(FLOOR_H)) begin
          valid_reg[gi] <= 1'b0;
          h_reg[gi]     <= 10'(FLOOR_H);
        end else begin
          h_reg[gi]     <= h_inc[9:0];
        end
      end
    end
  end

  always_comb begin
    valid_vec     = '0;
    slot_h_vec    = '0;
    slot_lane_vec = '0;
    for (int i = 0; i < NSLOT; i++) begin
      valid_vec[i]            = valid_reg[i];
      slot_h_vec[10*i +: 10]  = h_reg[i];
      slot_lane_vec[3*i +: 3] = lane_reg[i];
    end
  end

  assign bus.slot_valid = valid_vec;
  assign bus.slot_h     = slot_h_vec;
  assign bus.slot_lane  = slot_lane_vec;
  assign bus.state      = state_reg;

`ifdef BLOCK_SCHED_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      drop_cnt_reg <= '0;
    end else if (play && req_found && !free_found && drop_cnt_reg != 8'hFF) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign bus.drop_cnt = drop_cnt_reg;
`else
  assign bus.drop_cnt = 8'd0;
`endif

endmodule

// File: doc/block_sched.md
BLOCK_SCHED -- requirements
Module: block_sched

Interface
REQ-001 Parameter NSLOT, 4: number of shared falling-block slots (2..8).
REQ-002 Parameter SPAWN_H, 120: height loaded into a slot on allocation.
REQ-003 Parameter FLOOR_H, 720: height at which a slot is retired.
REQ-004 Parameter LAST_BEAT, 80: beat_cnt value that ends the song.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 restart  in  1  synchronous game restart, same effect as rst.
REQ-008 start  in  1  level; leaves IDLE.
REQ-009 pause  in  1  level; holds PLAY in PAUSE.
REQ-010 fall_tick  in  1  one-cycle strobe; advances valid slots.
REQ-011 beat_cnt  in  7  song beat counter, monotonic within a game.
REQ-012 slot_h  out  10*NSLOT  slot i height at bits [10i+9:10i].
REQ-013 slot_lane  out  3*NSLOT  slot i lane (0..4) at bits [3i+2:3i].
REQ-014 slot_valid  out  NSLOT  slot i holds a live block.
REQ-015 state  out  2  00 IDLE, 01 PLAY, 10 PAUSE, 11 END.
REQ-016 drop_cnt  out  8  requests refused for lack of a free slot.

Function
REQ-017 FSM: IDLE->PLAY on start; PLAY->PAUSE while pause=1; PAUSE->PLAY when pause=0; PLAY->END when beat_cnt>=LAST_BEAT, pending=0 and slot_valid=0; END is held until rst/restart.
REQ-018 Beat event: registered pre_beat; beat_add = beat_cnt > pre_beat; pre_beat updates every cycle in all states.
REQ-019 Beatmap, combinational on beat_cnt b: for even b in 4..76, lane (b>>1) mod 5 requested; if b is a nonzero multiple of 16, lane ((b>>1)+2) mod 5 is also requested; all other b request nothing.
REQ-020 On beat_add in PLAY, the beatmap mask is ORed into a 5-bit pending register; beat_add in IDLE, PAUSE or END is discarded.
REQ-021 Allocation, PLAY only: at most one per cycle; the lowest-index pending lane goes to the lowest-index free slot (valid=1, h=SPAWN_H, lane set); that pending bit clears.
REQ-022 If pending is nonzero and no slot is free, the lowest pending lane bit clears, the request is lost, and drop_cnt increments, saturating at 255.
REQ-023 A pending bit set and serviced in the same cycle: new beat bits OR in after the serviced bit clears, so a same-lane repeat is retained.
REQ-024 On fall_tick in PLAY, every valid slot allocated before this cycle adds 1 to h; a slot reaching h>=FLOOR_H clears valid and holds h=FLOOR_H.
REQ-025 A slot allocated in the same cycle as fall_tick is not advanced that cycle; a slot freed this cycle is allocatable next cycle.
REQ-026 In PAUSE, slot heights, pending and drop_cnt are frozen and fall_tick is ignored.
REQ-027 Height arithmetic is 10-bit unsigned and never wraps past FLOOR_H.

Reset
REQ-028 On rst or restart: state=IDLE, slot_valid=0, all slot_h=FLOOR_H, slot_lane=0, pending=0, pre_beat=0, drop_cnt=0.
REQ-029 rst/restart mid-allocation or mid-fall takes priority over all other updates in that cycle.

Configuration
REQ-030 Macro BLOCK_SCHED_DROP_CNT_EN defined: drop_cnt behaves as in REQ-022.
REQ-031 Macro undefined: the counter is not built, drop_cnt is constant 0, and refused requests are still discarded.

Verification
REQ-032 rst, start, beat_cnt 3->4 -> next cycle slot0 valid, lane 2, h=120; state=01.
REQ-033 PLAY, slot0 h=719, fall_tick -> slot0 valid=0, h=720; slot free on following beat.
REQ-034 beat_cnt 15->16 -> lanes 3 and 0 pending; cycle 1: lane 0 in slot0; cycle 2: lane 3 in slot1.
REQ-035 All 4 slots valid, beat 6 arrives -> no allocation, drop_cnt 0->1 (macro on) / stays 0 (macro off).
REQ-036 pause=1 for 10 fall_ticks -> heights unchanged, state=10; pause=0 -> resume from same heights.
REQ-037 beat_cnt=80, last slot retires -> state=11; restart pulse -> state=00, all slot_valid=0.
